io_input_buffer: RTL and testbench
==================================

// Module: io_input_buffer
// PURPOSE
//   Read-side counterpart of the IO output buffers: captures asynchronous external inputs
//   (switches, buttons), synchronises and debounces them, and holds a stable word for the
//   CPU load path. A sticky change flag tells software new data arrived; a read strobe
//   clears it. Sits between the board input pins and the IO read mux.
// PARAMETERS
//   WIDTH            32  width of input word / dout
//   SYNC_STAGES      2   synchroniser flops per bit (>=2)
//   DEBOUNCE_CYCLES  16  cycles the synced word must be unchanged before acceptance (>=1)
// PORTS
//   clk      in   1      system clock, all logic on rising edge
//   rst      in   1      synchronous, active-high reset
//   din      in   WIDTH  asynchronous external inputs
//   re       in   1      CPU read strobe (1 cycle); clears changed
//   dout     out  WIDTH  debounced stable word (registered)
//   changed  out  1      sticky: stable word updated to a new value since last re
//   edges    out  WIDTH  only with IO_BUF_EDGE_CAPTURE_EN (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst=1 at an edge): sync chain, cand, cnt, stable, changed, edges <= 0.
//     dout=0, changed=0 from the first edge with rst=1; reset mid-debounce discards
//     all progress, no partial update.
//   - Sync: s = din delayed SYNC_STAGES edges; no logic on din before the first flop.
//   - Debounce (whole word, one counter cnt, width max(1,$clog2(DEBOUNCE_CYCLES))):
//       s != cand                  -> cand<=s, cnt<=0
//       s == cand, cnt<DEBOUNCE-1  -> cnt<=cnt+1
//       s == cand, cnt==DEBOUNCE-1 -> cnt holds, stable<=cand
//   - Latency: din changes, then holds -> dout updates on edge SYNC_STAGES+1+DEBOUNCE_CYCLES
//     after the change (19 at defaults). Input held shorter than DEBOUNCE_CYCLES after sync
//     never reaches dout.
//   - Any bit change restarts the counter for the whole word.
//   - changed: set on the edge where stable<=cand and cand!=stable. Cleared on an edge with
//     re=1. Set and clear on the same edge -> set wins (changed stays 1).
//   - Rewriting the same value (cand==stable) never sets changed.
//   - re has no effect on dout, cand, or cnt. dout = stable, continuously.
//   - Counter saturates at DEBOUNCE_CYCLES-1, no wrap-around.
// CONFIGURATION
//   IO_BUF_EDGE_CAPTURE_EN defined:
//     - Port edges is present. Edge stable<=cand: edges <= edges | (stable ^ cand).
//       Edge with re=1: edges cleared, except bits set on that same edge.
//     - Captures per-bit toggles between reads.
//   IO_BUF_EDGE_CAPTURE_EN undefined:
//     - Port edges absent and no edge register is built.
//     - Other behaviour identical.
// TESTING (defaults: WIDTH=32, SYNC_STAGES=2, DEBOUNCE_CYCLES=16)
//   1 Reset: din=32'hFFFF_FFFF, rst=1 for 2 cycles then 0 -> dout=0 and changed=0 through
//     edge 18 after release; dout=32'hFFFF_FFFF, changed=1 at edge 19.
//   2 Glitch: from stable 0, din=32'h1 for 10 cycles then 0 -> dout stays 0, changed
//     stays 0 for 40 cycles.
//   3 Bounce: bit0 toggles every 5 cycles for 40 cycles, then held 1 -> dout=32'h1 exactly
//     19 edges after the last toggle, changed=1.
//   4 Read-clear: changed=1, re=1 for one cycle -> changed=0 after that edge; dout unchanged.
//   5 Collision: re=1 on the same edge stable takes a new value -> changed=1 after the edge.
//   6 Edge capture (macro on): din 0->32'h3, settle, then 32'h3->32'h1, settle ->
//     edges=32'h3; re pulse -> edges=0.
//     Macro off: design elaborates without the edges port.

Source files
------------

// File: rtl/io_input_buffer.sv
// io_input_buffer: synchronises and debounces asynchronous external inputs
// into a stable word for the CPU read path. A sticky 'changed' flag marks
// new data and is cleared by the read strobe 're'.
// Optional feature macro: IO_BUF_EDGE_CAPTURE_EN adds the 'edges' port,
// which accumulates per-bit toggles of the stable word between reads.
module io_input_buffer #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             changed
`ifdef IO_BUF_EDGE_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] edges
`endif
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser chain: stage 0 samples din directly, last stage feeds debounce.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  s;

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic             changed_q, changed_d;
  logic             accept;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the synchroniser chain by one stage per clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // Whole-word debounce: any difference restarts the count; a saturated
  // count keeps reloading stable from cand every cycle.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept   = 1'b0;
    if (s != cand_q) begin
      cand_d = s;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      stable_d = cand_q;
      accept   = 1'b1;
    end
  end

  // Sticky change flag: a genuine new value wins over a same-edge read clear.
  always_comb begin
    changed_d = (changed_q & ~re) | (accept & (cand_q != stable_q));
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

  assign dout    = stable_q;
  assign changed = changed_q;

`ifdef IO_BUF_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] edges_q, edges_d;

  // Accumulate toggled bits; a read clears all but bits set on the same edge.
  always_comb begin
    edges_d = (re ? '0 : edges_q) | (accept ? (stable_q ^ cand_q) : '0);
  end

  // Edge register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) edges_q <= '0;
    else     edges_q <= edges_d;
  end

  assign edges = edges_q;
`endif

endmodule

// File: tb/tb_io_input_buffer.sv
// Testbench for io_input_buffer: directed vector table, hand-written corner
// sequences and randomized stimulus, all checked against a run-length model.
module tb_io_input_buffer;

  localparam int unsigned W  = 32;
  localparam int unsigned SS = 2;
  localparam int unsigned DB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  din = '0;
  logic          re  = 1'b0;
  logic [W-1:0]  dout;
  logic          changed;
`ifdef IO_BUF_EDGE_CAPTURE_EN
  logic [W-1:0]  edges;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_input_buffer #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .re(re),
    .dout(dout),
    .changed(changed)
`ifdef IO_BUF_EDGE_CAPTURE_EN
    ,
    .edges(edges)
`endif
  );

  // Reference model: the debouncer sees din delayed SS edges; the stable
  // word takes a value once that value has been seen on DB+1 consecutive edges.
  logic [W-1:0] m_pipe[$];
  logic [W-1:0] m_last;
  int unsigned  m_run;
  logic [W-1:0] m_stable;
  logic         m_changed;
  logic [W-1:0] m_edges;

  task automatic model_edge();
    logic [W-1:0] v;
    logic [W-1:0] diff;
    if (rst) begin
      m_pipe.delete();
      for (int i = 0; i < int'(SS); i++) m_pipe.push_back('0);
      m_last    = '0;
      m_run     = 1;
      m_stable  = '0;
      m_changed = 1'b0;
      m_edges   = '0;
    end else begin
      v = m_pipe.pop_front();
      m_pipe.push_back(din);
      if (v == m_last) begin
        if (m_run <= DB) m_run++;
      end else begin
        m_last = v;
        m_run  = 1;
      end
      diff = '0;
      if (m_run >= DB + 1) begin
        diff     = v ^ m_stable;
        m_stable = v;
      end
      if (re) begin
        m_changed = 1'b0;
        m_edges   = '0;
      end
      if (diff != '0) m_changed = 1'b1;
      m_edges = m_edges | diff;
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: inputs already driven; compare against model #1 after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_dout", dout, m_stable);
    chk("model_changed", W'(changed), W'(m_changed));
`ifdef IO_BUF_EDGE_CAPTURE_EN
    chk("model_edges", edges, m_edges);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] din;
    logic         re;
    int           cycles;
    logic [W-1:0] exp_dout;
    logic         exp_changed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [W-1:0] d, input logic rd,
                              input int n, input logic [W-1:0] ed, input logic ec);
    vec_t v;
    v.rst = r; v.din = d; v.re = rd; v.cycles = n; v.exp_dout = ed; v.exp_changed = ec;
    vecs.push_back(v);
  endfunction

  logic [W-1:0] cur;
  logic [W-1:0] val;
  int           len;

  initial begin
    // Reset with all-ones input, release, latency 19, read-clear, rewrite same
    // value, fall to zero, then a 10-cycle glitch that must never be accepted.
    add(1, 32'hFFFF_FFFF, 0,  2, 32'h0,         0);
    add(0, 32'hFFFF_FFFF, 0, 18, 32'h0,         0);
    add(0, 32'hFFFF_FFFF, 0,  1, 32'hFFFF_FFFF, 1);
    add(0, 32'hFFFF_FFFF, 1,  1, 32'hFFFF_FFFF, 0);
    add(0, 32'hFFFF_FFFF, 0, 25, 32'hFFFF_FFFF, 0);
    add(0, 32'h0,         0, 18, 32'hFFFF_FFFF, 0);
    add(0, 32'h0,         0,  1, 32'h0,         1);
    add(0, 32'h0,         1,  1, 32'h0,         0);
    add(0, 32'h1,         0, 10, 32'h0,         0);
    add(0, 32'h0,         0, 40, 32'h0,         0);
    add(1, 32'hA5A5_0F0F, 0,  1, 32'h0,         0);
    add(0, 32'hA5A5_0F0F, 0, 19, 32'hA5A5_0F0F, 1);
    add(0, 32'h0,         0, 10, 32'hA5A5_0F0F, 1);
    add(1, 32'h0,         0,  1, 32'h0,         0);
    add(0, 32'h0,         0, 30, 32'h0,         0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; din = vecs[i].din; re = vecs[i].re;
      run(vecs[i].cycles);
      chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      chk($sformatf("vec%0d_changed", i), W'(changed), W'(vecs[i].exp_changed));
    end
    rst = 0; re = 0;

    // Bounce: bit0 toggles every 5 cycles, then held 1; accepted exactly 19 edges later.
    for (int i = 0; i < 8; i++) begin
      din = (i % 2 == 0) ? 32'h1 : 32'h0;
      run(5);
    end
    din = 32'h1;
    for (int k = 1; k <= 19; k++) begin
      step();
      chk($sformatf("bounce_dout_e%0d", k), dout, (k == 19) ? 32'h1 : 32'h0);
    end
    chk("bounce_changed", W'(changed), W'(1));

    // Collision: read strobe on the very edge a new value is accepted.
    din = 32'h0;
    run(18);
    chk("collide_pre_dout", dout, 32'h1);
    re = 1;
    step();
    re = 0;
    chk("collide_dout", dout, 32'h0);
    chk("collide_changed", W'(changed), W'(1));
    re = 1;
    step();
    re = 0;
    chk("readclr_changed", W'(changed), W'(0));
    chk("readclr_dout", dout, 32'h0);

`ifdef IO_BUF_EDGE_CAPTURE_EN
    // Edge capture: 0 -> 3 -> 1 leaves edges = 3; a read clears it.
    re = 1; step(); re = 0;
    din = 32'h3; run(25);
    din = 32'h1; run(25);
    chk("edges_acc", edges, 32'h3);
    re = 1; step(); re = 0;
    chk("edges_clr", edges, 32'h0);
`endif

    // Randomized segments of held values, random reads and rare resets.
    cur = 32'h0;
    for (int seg = 0; seg < 150; seg++) begin
      case ($urandom_range(0, 3))
        0:       val = $urandom;
        1:       val = cur ^ (32'h1 << $urandom_range(0, 31));
        2:       val = cur;
        default: val = '0;
      endcase
      cur = val;
      len = $urandom_range(1, 30);
      for (int k = 0; k < len; k++) begin
        din = val;
        re  = ($urandom_range(0, 7) == 0);
        rst = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    rst = 0; re = 0;
    run(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
